uart_rx_cfg: RTL and testbench

Runtime-configurable UART receiver, successor to the fixed 8N1 receiver in the UART mux datapath. Frame format (5–9 data bits, none/even/odd parity, 1 or 2 stop bits) is selected per frame from input ports. Adds an input synchronizer, 3-sample majority voting, and parity, framing and break reporting. Output feeds the mux channel FIFOs via a single-cycle `done_tick`.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_cfg_if.sv | 35 +++
 rtl/uart_rx_sync_vote.sv | 33 +++
 rtl/uart_rx_cfg.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive paths: FSM state encoding,
// parity-mode constants and the majority-vote helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int DATA_BITS_MIN = 5;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Bundle of the receiver's serial input, per-frame format controls and
// completed-frame outputs, plus the FSM state for observation.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS_MAX = 9,
    parameter int COUNTER_BITS  = 16
);
    import uart_pkg::*;

    logic                     rx;
    logic [COUNTER_BITS-1:0]  baud_divisor;
    logic [3:0]               data_bits;
    logic [1:0]               parity_mode;
    logic                     stop_bits;

    // done_tick is a one-cycle valid with no ready: the consumer must capture
    // data_out and the flags in that cycle; they then hold until the next tick.
    logic                     done_tick;
    logic [DATA_BITS_MAX-1:0] data_out;
    logic                     parity_err;
    logic                     frame_err;
    logic                     break_det;
    logic                     busy;
    uart_state_t              state;

    modport master (
        output rx, baud_divisor, data_bits, parity_mode, stop_bits,
        input  done_tick, data_out, parity_err, frame_err, break_det, busy, state
    );

    modport slave (
        input  rx, baud_divisor, data_bits, parity_mode, stop_bits,
        output done_tick, data_out, parity_err, frame_err, break_det, busy, state
    );

endinterface

// File: rtl/uart_rx_sync_vote.sv
// Two-flop synchronizer for an asynchronous serial line followed by a
// 3-deep history and majority vote used as the bit sample.
module uart_rx_sync_vote
    import uart_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic vote
);

    logic       sync1;
    logic       sync2;
    logic [1:0] hist;

    // Everything resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 2'b11;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            hist  <= {hist[0], sync2};
        end
    end

    assign rx_s = sync2;
    assign vote = maj3({hist, sync2});

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5..9 data bits, none/even/odd parity,
// 1 or 2 stop bits, with parity, framing and break reporting.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS_MAX = 9,
    parameter int COUNTER_BITS  = 16
) (
    input  logic        clk,
    input  logic        reset,
    uart_rx_cfg_if.slave bus
);

    logic                     rx_s;
    logic                     vote;

    uart_state_t              state;
    logic [COUNTER_BITS-1:0]  cnt;
    logic [3:0]               bit_idx;
    logic [3:0]               nbits_q;
    logic                     par_en_q;
    logic                     par_odd_q;
    logic                     stop2_q;
    logic                     stop_idx;
    logic                     par_q;
    logic                     stop0_q;
    logic [DATA_BITS_MAX-1:0] shift;

    logic                     done_tick;
    logic [DATA_BITS_MAX-1:0] data_out;
    logic                     parity_err;
    logic                     frame_err;
    logic                     break_det;

    logic [3:0]               nbits_cfg;
    logic                     half_tick;
    logic                     bit_tick;
    logic                     frame_bad;
    logic                     brk;
    logic                     par_bad;

    uart_rx_sync_vote u_sync_vote (
        .clk   (clk),
        .reset (reset),
        .rx    (bus.rx),
        .rx_s  (rx_s),
        .vote  (vote)
    );

    always_comb begin
        nbits_cfg = bus.data_bits;
        if (bus.data_bits < 4'(DATA_BITS_MIN)) begin
            nbits_cfg = 4'(DATA_BITS_MIN);
        end else if (bus.data_bits > 4'(DATA_BITS_MAX)) begin
            nbits_cfg = 4'(DATA_BITS_MAX);
        end
    end

    assign half_tick = (cnt == (bus.baud_divisor >> 1));
    assign bit_tick  = (cnt == bus.baud_divisor);

    // Evaluated in the final stop-sample cycle, where vote is that last stop bit.
    always_comb begin
        frame_bad = ~vote | (stop2_q & ~stop0_q);
        brk       = (shift == '0) & ~(par_en_q & par_q) & ~vote & ~(stop2_q & stop0_q);
        par_bad   = par_en_q & ((^shift) ^ par_q ^ par_odd_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            nbits_q    <= 4'(DATA_BITS_MIN);
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_idx   <= 1'b0;
            par_q      <= 1'b0;
            stop0_q    <= 1'b0;
            shift      <= '0;
            done_tick  <= 1'b0;
            data_out   <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            done_tick <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state     <= START;
                        cnt       <= '0;
                        nbits_q   <= nbits_cfg;
                        par_en_q  <= (bus.parity_mode == PAR_EVEN) || (bus.parity_mode == PAR_ODD);
                        par_odd_q <= (bus.parity_mode == PAR_ODD);
                        stop2_q   <= bus.stop_bits;
                        shift     <= '0;
                    end
                end
                START: begin
                    if (half_tick) begin
                        if (vote) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            cnt     <= '0;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift[bit_idx] <= vote;
                        cnt            <= '0;
                        bit_idx        <= bit_idx + 4'd1;
                        if (bit_idx == nbits_q - 4'd1) begin
                            state    <= par_en_q ? PARITY : STOP;
                            stop_idx <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        par_q <= vote;
                        cnt   <= '0;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        cnt <= '0;
                        if (stop2_q && !stop_idx) begin
                            stop0_q  <= vote;
                            stop_idx <= 1'b1;
                        end else begin
                            done_tick  <= 1'b1;
                            data_out   <= shift;
                            parity_err <= par_bad;
                            frame_err  <= frame_bad | brk;
                            break_det  <= brk;
                            // A low final stop bit parks in WAIT so a held-low line cannot retrigger.
                            state      <= vote ? IDLE : WAIT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.done_tick  = done_tick;
    assign bus.data_out   = data_out;
    assign bus.parity_err = parity_err;
    assign bus.frame_err  = frame_err;
    assign bus.break_det  = break_det;
    assign bus.busy       = (state != IDLE);
    assign bus.state      = state;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: frames are driven bit by bit, the expected
// frame result is queued at issue time and a monitor checks each done_tick.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int BD       = 15;
    localparam int BIT_CLKS = BD + 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_rx_cfg_if #(.DATA_BITS_MAX(9), .COUNTER_BITS(16)) bus ();

    uart_rx_cfg #(.DATA_BITS_MAX(9), .COUNTER_BITS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Expected entry: {break_det, frame_err, parity_err, data_out[8:0]}
    logic [11:0] exp_q[$];
    logic [11:0] mon_exp;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_ticks  = 0;
    logic        saw_data;
    int          busy_cycles;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset && bus.done_tick) begin
            n_ticks++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_tick: got tick with data 0x%0h, expected no tick", bus.data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                check("frame", {20'd0, bus.break_det, bus.frame_err, bus.parity_err, bus.data_out},
                      {20'd0, mon_exp});
            end
        end
        if (!reset && bus.state == DATA) saw_data = 1'b1;
        if (!reset && bus.busy) busy_cycles++;
    end

    // ---------------- driver tasks ----------------
    task automatic set_cfg(input logic [3:0] nb, input logic [1:0] pm, input logic s2);
        bus.data_bits   = nb;
        bus.parity_mode = pm;
        bus.stop_bits   = s2;
    endtask

    task automatic expect_frame(input logic brk, input logic fe, input logic pe, input logic [8:0] d);
        exp_q.push_back({brk, fe, pe, d});
    endtask

    task automatic drive_bit(input logic b);
        bus.rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Data, optional parity (pbit < 0 means none) and stop bits; last stop bit takes stop_val.
    task automatic send_body(input logic [8:0] d, input int nb, input int pbit, input int nstop,
                             input logic stop_val);
        for (int i = 0; i < nb; i++) drive_bit(d[i]);
        if (pbit >= 0) drive_bit(pbit[0]);
        for (int i = 0; i < nstop; i++) drive_bit((i == nstop - 1) ? stop_val : 1'b1);
    endtask

    task automatic send_frame(input logic [8:0] d, input int nb, input int pbit, input int nstop,
                              input logic stop_val);
        drive_bit(1'b0);
        send_body(d, nb, pbit, nstop, stop_val);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- sequence ----------------
    initial begin
        int t0;
        reset            = 1'b1;
        bus.rx           = 1'b1;
        bus.baud_divisor = 16'(BD);
        set_cfg(4'd8, PAR_NONE, 1'b0);
        repeat (3) @(negedge clk);
        check("reset_outputs", {26'd0, bus.done_tick, bus.break_det, bus.frame_err, bus.parity_err,
              bus.busy, bus.data_out == 9'd0}, 32'd1);
        check("reset_state", 32'(bus.state), 32'(IDLE));
        reset = 1'b0;
        idle(5);

        // 8N1 0xA5 with busy latency probe on the start bit
        expect_frame(1'b0, 1'b0, 1'b0, 9'h0A5);
        bus.rx = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_latency_2clk", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("busy_latency_3clk", 32'(bus.busy), 32'd1);
        repeat (BIT_CLKS - 3) @(negedge clk);
        send_body(9'h0A5, 8, -1, 1, 1'b1);
        idle(BIT_CLKS);
        wait_drain("drain_a5");
        check("busy_after_a5", 32'(bus.busy), 32'd0);

        // 7E2 0x41, wrong then right parity
        set_cfg(4'd7, PAR_EVEN, 1'b1);
        expect_frame(1'b0, 1'b0, 1'b1, 9'h041);
        send_frame(9'h041, 7, 1, 2, 1'b1);
        idle(2 * BIT_CLKS);
        expect_frame(1'b0, 1'b0, 1'b0, 9'h041);
        send_frame(9'h041, 7, 0, 2, 1'b1);
        idle(2 * BIT_CLKS);
        wait_drain("drain_7e2");

        // 9O1 0x1FF, correct parity bit 0
        set_cfg(4'd9, PAR_ODD, 1'b0);
        expect_frame(1'b0, 1'b0, 1'b0, 9'h1FF);
        send_frame(9'h1FF, 9, 0, 1, 1'b1);
        idle(2 * BIT_CLKS);
        wait_drain("drain_9o1");

        // Clamping: data_bits 3 -> 5 with mode 11 (no parity); data_bits 15 -> 9
        set_cfg(4'd3, 2'b11, 1'b0);
        expect_frame(1'b0, 1'b0, 1'b0, 9'h015);
        send_frame(9'h015, 5, -1, 1, 1'b1);
        idle(2 * BIT_CLKS);
        set_cfg(4'd15, PAR_NONE, 1'b0);
        expect_frame(1'b0, 1'b0, 1'b0, 9'h155);
        send_frame(9'h155, 9, -1, 1, 1'b1);
        idle(2 * BIT_CLKS);
        wait_drain("drain_clamp");

        // One-clock glitch in IDLE: false start, no DATA, no tick
        set_cfg(4'd8, PAR_NONE, 1'b0);
        saw_data    = 1'b0;
        busy_cycles = 0;
        t0          = n_ticks;
        bus.rx = 1'b0;
        @(negedge clk);
        bus.rx = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clk);
        check("glitch_no_data", 32'(saw_data), 32'd0);
        check("glitch_busy_cycles", 32'(busy_cycles), 32'((BD >> 1) + 1));
        check("glitch_no_tick", 32'(n_ticks - t0), 32'd0);

        // Break: line low for three 8N1 frame times
        expect_frame(1'b1, 1'b1, 1'b0, 9'h000);
        t0     = n_ticks;
        bus.rx = 1'b0;
        repeat (3 * 10 * BIT_CLKS) @(negedge clk);
        check("break_one_tick", 32'(n_ticks - t0), 32'd1);
        check("break_state_wait", 32'(bus.state), 32'(WAIT));
        idle(2 * BIT_CLKS);
        check("break_no_retrigger", 32'(n_ticks - t0), 32'd1);
        expect_frame(1'b0, 1'b0, 1'b0, 9'h055);
        send_frame(9'h055, 8, -1, 1, 1'b1);
        idle(2 * BIT_CLKS);
        wait_drain("drain_break");

        // Stop bit low on 0x3C: frame error, then WAIT until line high
        expect_frame(1'b0, 1'b1, 1'b0, 9'h03C);
        send_frame(9'h03C, 8, -1, 1, 1'b0);
        repeat (3 * BIT_CLKS) @(negedge clk);
        check("stoplow_state_wait", 32'(bus.state), 32'(WAIT));
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
        check("stoplow_state_idle", 32'(bus.state), 32'(IDLE));
        idle(2 * BIT_CLKS);
        wait_drain("drain_stoplow");

        // Reset during data bit 4 of an aborted frame, then a clean 0x5A
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h5A >> i));
        bus.rx = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_outputs", {26'd0, bus.done_tick, bus.break_det, bus.frame_err,
              bus.parity_err, bus.busy, bus.data_out == 9'd0}, 32'd1);
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        idle(2 * BIT_CLKS);
        expect_frame(1'b0, 1'b0, 1'b0, 9'h05A);
        send_frame(9'h05A, 8, -1, 1, 1'b1);
        idle(2 * BIT_CLKS);
        wait_drain("drain_reset");
        check("final_busy", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
